uart_cmd_slave: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 rtl/uart_cmd_slave.sv | 213 +++++++++++++++++++++
 tb/tb_uart_cmd_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 2-byte UART command protocol: FSM encoding,
// command-byte layout and the default bit period.
package uart_pkg;

    localparam int DEFAULT_BR = 434;

    localparam int   CMD_RW_BIT = 7;
    localparam logic CMD_WRITE  = 1'b1;
    localparam logic CMD_READ   = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_DATA,
        WR,
        RD_REQ,
        RD_LATCH,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start-bit validation at half a bit,
// mid-bit sampling; emits a one-cycle byte_vld with parity and stop status.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BR         = DEFAULT_BR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  rx,
    output logic                  byte_vld,
    output logic [DATA_WIDTH-1:0] byte_data,
    output logic                  parity_ok,
    output logic                  stop_ok,
    output logic                  rx_active
);

    localparam int             CW      = $clog2(BR);
    localparam logic [CW-1:0]  HALF    = CW'(BR / 2 - 1);
    localparam logic [CW-1:0]  LAST    = CW'(BR - 1);
    localparam logic [3:0]     PAR_IDX = 4'(DATA_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_e;

    rx_state_e             rx_state_q, rx_state_d;
    logic                  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  vld_q, vld_d;
    logic                  pok_q, pok_d, sok_q, sok_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sync1_d    = rx;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        vld_d      = 1'b0;
        pok_d      = pok_q;
        sok_d      = sok_q;

        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < PAR_IDX) begin
                        shift_d = {sync2_q, shift_q[DATA_WIDTH-1:1]};
                    end else if (bit_q == PAR_IDX) begin
                        par_d = sync2_q;
                    end else begin
                        vld_d      = 1'b1;
                        pok_d      = ((^shift_q) == par_q);
                        sok_d      = sync2_q;
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // Disabled while transmitting: any partial reception is dropped.
        if (!en) begin
            rx_state_d = RX_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            vld_q      <= 1'b0;
            pok_q      <= 1'b0;
            sok_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rx_state_q <= rx_state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            vld_q      <= vld_d;
            pok_q      <= pok_d;
            sok_q      <= sok_d;
        end
    end

    assign byte_vld  = vld_q;
    assign byte_data = shift_q;
    assign parity_ok = pok_q;
    assign stop_ok   = sok_q;
    assign rx_active = (rx_state_q == RX_BITS);

endmodule

// File: rtl/uart_cmd_slave.sv
// UART command responder: decodes write/read command frames into register-file
// strobes and returns read data on tx with the same framing (half duplex).
module uart_cmd_slave
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 7,
    parameter int BR           = DEFAULT_BR,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int             CW       = $clog2(BR);
    localparam logic [CW-1:0]  LAST     = CW'(BR - 1);
    localparam logic [3:0]     LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam int             TO_LIMIT = TIMEOUT_BITS * BR;
    localparam int             TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0]  TO_MAX   = TW'(TO_LIMIT);

    state_e                state_q, state_d;
    logic                  tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TW-1:0]         to_q, to_d;

    logic                  rx_en, byte_vld, parity_ok, stop_ok, rx_active, byte_ok;
    logic [DATA_WIDTH-1:0] byte_data;

    assign rx_en   = (state_q == IDLE) || (state_q == WAIT_DATA);
    assign byte_ok = byte_vld && parity_ok && stop_ok;

    uart_rx_byte #(
        .DATA_WIDTH (DATA_WIDTH),
        .BR         (BR)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (rx_en),
        .rx         (rx),
        .byte_vld   (byte_vld),
        .byte_data  (byte_data),
        .parity_ok  (parity_ok),
        .stop_ok    (stop_ok),
        .rx_active  (rx_active)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        err_d     = 1'b0;
        wr_data_d = wr_data_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_d      = to_q;

        case (state_q)
            IDLE: begin
                if (byte_vld) begin
                    if (!byte_ok) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = byte_data[ADDR_WIDTH-1:0];
                        if (byte_data[CMD_RW_BIT] == CMD_WRITE) begin
                            state_d = WAIT_DATA;
                            to_d    = '0;
                        end else if (byte_data[CMD_RW_BIT] == CMD_READ) begin
                            state_d = RD_REQ;
                            rd_en_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                if (byte_vld) begin
                    if (byte_ok) begin
                        wr_data_d = byte_data;
                        wr_en_d   = 1'b1;
                        state_d   = WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (!rx_active) begin
                    // Timer stops once byte1's start bit has been validated.
                    if (to_q == TO_MAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            WR:     state_d = IDLE;
            RD_REQ: state_d = RD_LATCH;
            RD_LATCH: begin
                shift_d = reg_rd_data;
                par_d   = ^reg_rd_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = TX_START;
            end
            TX_START: begin
                if (baud_q == LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_q == LAST) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        tx_d    = par_q;
                        state_d = TX_PARITY;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_PARITY: begin
                if (baud_q == LAST) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = TX_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_q == LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            err_q     <= err_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_q      <= to_d;
        end
    end

    assign tx          = tx_q;
    assign reg_addr    = addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_en   = rd_en_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave: stimulus pushes expected events, two
// monitors (strobes, decoded tx frames) pop and compare them.
module tb_uart_cmd_slave;

    localparam int BR  = 16;
    localparam int DW  = 8;
    localparam int AW  = 7;
    localparam int TOB = 20;

    typedef enum int {EV_WR, EV_RD, EV_ERR, EV_TX} ev_kind_e;
    typedef struct {
        ev_kind_e       kind;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx    = 1'b1;
    logic          tx;
    logic [AW-1:0] reg_addr;
    logic          reg_wr_en;
    logic [DW-1:0] reg_wr_data;
    logic          reg_rd_en;
    logic [DW-1:0] reg_rd_data;
    logic          frame_err;
    logic          busy;

    uart_cmd_slave #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BR           (BR),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .tx          (tx),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (a == 7'h12) return 8'hA5;
        return {a[3:0], a[6:3]} ^ 8'h6B;
    endfunction

    // Register file: data valid exactly one cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        reg_rd_data <= reg_rd_en ? rd_val(reg_addr) : 8'($urandom);
    end

    always @(negedge clk) begin : strobe_mon
        ev_t e;
        if (rst_n && (reg_wr_en || reg_rd_en || frame_err)) begin
            check("single_event", 32'(int'(reg_wr_en) + int'(reg_rd_en) + int'(frame_err)), 1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got wr=%0b rd=%0b err=%0b expected none",
                         reg_wr_en, reg_rd_en, frame_err);
            end else begin
                e = exp_q.pop_front();
                if (reg_wr_en) begin
                    check("wr_kind", 32'(EV_WR), 32'(e.kind));
                    check("wr_addr", 32'(reg_addr), 32'(e.addr));
                    check("wr_data", 32'(reg_wr_data), 32'(e.data));
                end else if (reg_rd_en) begin
                    check("rd_kind", 32'(EV_RD), 32'(e.kind));
                    check("rd_addr", 32'(reg_addr), 32'(e.addr));
                end else begin
                    check("err_kind", 32'(EV_ERR), 32'(e.kind));
                end
            end
        end
    end

    task automatic wait_neg(input int n, inout bit aborted);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
        end
    endtask

    initial begin : tx_mon
        logic [10:0] bits;
        bit          aborted;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                aborted = 1'b0;
                wait_neg(BR / 2 - 1, aborted);
                bits[0] = tx;
                for (int k = 1; k < 11; k++) begin
                    wait_neg(BR, aborted);
                    bits[k] = tx;
                end
                if (!aborted) begin
                    check("tx_start_bit", 32'(bits[0]), 0);
                    check("tx_stop_bit", 32'(bits[10]), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx: got 0x%0h expected none", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_kind", 32'(EV_TX), 32'(e.kind));
                        check("tx_data", 32'(bits[8:1]), 32'(e.data));
                        check("tx_parity", 32'(bits[9]), 32'(^e.data));
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (BR) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(busy), 0);
        repeat ($urandom_range(2, 12)) @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{kind: EV_WR, addr: a, data: d});
        send_frame({1'b1, a}, 1'b0, 1'b0);
        send_frame(d, 1'b0, 1'b0);
        wait_idle(100);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_q.push_back('{kind: EV_RD, addr: a, data: '0});
        exp_q.push_back('{kind: EV_TX, addr: a, data: rd_val(a)});
        send_frame({1'b0, a}, 1'b0, 1'b0);
        wait_idle(400);
    endtask

    task automatic do_bad_byte0(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        exp_q.push_back('{kind: EV_ERR, addr: '0, data: '0});
        send_frame(b, bad_par, bad_stop);
        wait_idle(100);
    endtask

    task automatic do_bad_byte1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{kind: EV_ERR, addr: '0, data: '0});
        send_frame({1'b1, a}, 1'b0, 1'b0);
        send_frame(d, 1'b1, 1'b0);
        wait_idle(100);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion expected completion within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  n;
        bit  saw_busy;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_en", 32'(reg_wr_en), 0);
        check("rst_rd_en", 32'(reg_rd_en), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_addr", 32'(reg_addr), 0);
        check("rst_wr_data", 32'(reg_wr_data), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_write(7'h05, 8'h3C);
        do_read(7'h12);

        do_bad_byte0(8'h85, 1'b1, 1'b0);
        do_read(7'h12);

        exp_q.push_back('{kind: EV_ERR, addr: '0, data: '0});
        send_frame(8'h85, 1'b0, 1'b0);
        repeat (TOB * BR + 20) @(negedge clk);
        wait_idle(100);
        do_write(7'h05, 8'h3C);

        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy", 32'(saw_busy), 0);

        exp_q.push_back('{kind: EV_RD, addr: 7'h12, data: '0});
        exp_q.push_back('{kind: EV_TX, addr: 7'h12, data: rd_val(7'h12)});
        send_frame(8'h12, 1'b0, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_started_before_reset", 32'(tx), 0);
        repeat (BR * 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 1);
        check("async_rst_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_read(7'h12);

        for (int i = 0; i < 40; i++) begin
            int            kind;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            kind = $urandom_range(0, 9);
            a    = 7'($urandom);
            d    = 8'($urandom);
            if (kind < 4)       do_write(a, d);
            else if (kind < 8)  do_read(a);
            else if (kind == 8) do_bad_byte0(d, 1'($urandom), 1'b1);
            else                do_bad_byte1(a, d);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
